// File: rtl/ref_tracker.sv
// ---------------------------------------------------------------------------
// ref_tracker
//
// Measures the period of an external reference pin in system clock cycles and
// turns it into a DDS phase increment floor(2^32 / P). It also reports
// whether the reference is stable (locked) or missing (noref).
//
// Ports
//   clk        in   1      system clock
//   rst        in   1      synchronous reset, active-low
//   refin      in   1      asynchronous reference pin
//   phase_inc  out  32     DDS phase increment, floor(2^32 / P), registered
//   inc_valid  out  1      one-cycle strobe in the cycle phase_inc changes
//   period     out  CNT_W  last accepted period, in cycles
//   locked     out  1      LOCK_N consecutive in-tolerance periods seen
//   noref      out  1      no valid reference (after reset or timeout)
//   dbg_state  out  2      divider FSM state (0 IDLE, 1 DIV, 2 DONE)
//
// Strobe semantics: inc_valid has no back-pressure. It is high for exactly
// one cycle, and phase_inc and locked already show their new values in that
// cycle. A consumer must sample in that cycle.
//
// MIN_PERIOD must be at least 40. The divider needs 34 cycles from an
// accepted edge back to IDLE, so the next accepted edge always finds it idle.
// ---------------------------------------------------------------------------
module ref_tracker #(
    parameter int CNT_W      = 20,
    parameter int MIN_PERIOD = 64,
    parameter int TOL_SH     = 4,
    parameter int LOCK_N     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             refin,
    output logic [31:0]      phase_inc,
    output logic             inc_valid,
    output logic [CNT_W-1:0] period,
    output logic             locked,
    output logic             noref,
    output logic [1:0]       dbg_state
);

    localparam int LC_W = $clog2(LOCK_N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic              w_inc_valid;

    // Input conditioning
    logic              r_s1, r_s2, r_d;

    // Measurement and status
    logic [CNT_W-1:0]  r_cnt;
    logic              r_armed;
    logic              r_noref;
    logic [CNT_W-1:0]  r_period;
    logic [31:0]       r_phase_inc;
    logic              r_locked;
    logic [LC_W-1:0]   r_lock_cnt;
    logic [CNT_W-1:0]  r_prev;
    logic              r_prev_valid;

    // Divider datapath
    logic [CNT_W-1:0]  r_div;
    logic [CNT_W:0]    r_rem;
    logic [31:0]       r_quo;
    logic [5:0]        r_iter;

    logic              w_edge, w_sat, w_arm, w_accept, w_start, w_last;
    logic [CNT_W:0]    w_rem_sh, w_rem_nx;
    logic              w_ge;
    logic [31:0]       w_quo_nx;
    logic [CNT_W-1:0]  w_diff, w_tol;
    logic              w_in_tol;

    assign w_edge   = r_s2 & ~r_d;
    assign w_sat    = (r_cnt == {CNT_W{1'b1}});
    // A saturated counter means timeout. The timeout takes priority, and an
    // edge in that same cycle only re-arms.
    assign w_arm    = w_edge & ~r_armed;
    assign w_accept = w_edge & r_armed & ~w_sat & (r_cnt >= CNT_W'(MIN_PERIOD));
    assign w_start  = w_accept & (r_state == S_IDLE);
    assign w_last   = (r_state == S_DIV) & (r_iter == 6'd1);

    // One restoring-division step. The stored remainder is always below the
    // divisor, so the left shift cannot lose a set bit.
    assign w_rem_sh = r_rem << 1;
    assign w_ge     = (w_rem_sh >= {1'b0, r_div});
    assign w_rem_nx = w_ge ? (w_rem_sh - {1'b0, r_div}) : w_rem_sh;
    assign w_quo_nx = {r_quo[30:0], w_ge};

    // Lock tolerance: |P - P_prev| <= P_prev >> TOL_SH
    assign w_diff   = (r_div >= r_prev) ? (r_div - r_prev) : (r_prev - r_div);
    assign w_tol    = r_prev >> TOL_SH;
    assign w_in_tol = (w_diff <= w_tol);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_inc_valid = 1'b0;
        case (r_state)
            S_IDLE: if (w_start) w_state_nx = S_DIV;
            S_DIV:  if (r_iter == 6'd1) w_state_nx = S_DONE;
            S_DONE: begin
                w_inc_valid = 1'b1;
                w_state_nx  = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1         <= 1'b0;
            r_s2         <= 1'b0;
            r_d          <= 1'b0;
            r_cnt        <= '0;
            r_armed      <= 1'b0;
            r_noref      <= 1'b1;
            r_period     <= '0;
            r_phase_inc  <= '0;
            r_locked     <= 1'b0;
            r_lock_cnt   <= '0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_div        <= '0;
            r_rem        <= '0;
            r_quo        <= '0;
            r_iter       <= '0;
        end else begin
            r_s1 <= refin;
            r_s2 <= r_s1;
            r_d  <= r_s2;

            if (w_sat) begin
                r_cnt   <= w_edge ? CNT_W'(1) : r_cnt;
                r_armed <= w_edge;
            end else if (w_arm || w_accept) begin
                r_cnt   <= CNT_W'(1);
                r_armed <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            // Dividend 2^32: the leading 1 is the initial remainder, and the
            // 32 zero bits below it are shifted in one per cycle.
            if (w_start) begin
                r_period <= r_cnt;
                r_noref  <= 1'b0;
                r_div    <= r_cnt;
                r_rem    <= (CNT_W + 1)'(1);
                r_quo    <= '0;
                r_iter   <= 6'd32;
            end else if (r_state == S_DIV) begin
                r_rem  <= w_rem_nx;
                r_quo  <= w_quo_nx;
                r_iter <= r_iter - 1'b1;
            end

            // Registered on the last DIV cycle, so the results are visible
            // in the DONE cycle together with inc_valid.
            if (w_last) begin
                r_phase_inc  <= w_quo_nx;
                r_prev       <= r_div;
                r_prev_valid <= 1'b1;
                if (r_prev_valid) begin
                    if (w_in_tol) begin
                        if (r_lock_cnt < LC_W'(LOCK_N)) r_lock_cnt <= r_lock_cnt + 1'b1;
                        if (r_lock_cnt >= LC_W'(LOCK_N - 1)) r_locked <= 1'b1;
                    end else begin
                        r_lock_cnt <= '0;
                        r_locked   <= 1'b0;
                    end
                end
            end

            if (w_sat) begin
                r_noref      <= 1'b1;
                r_locked     <= 1'b0;
                r_lock_cnt   <= '0;
                r_prev_valid <= 1'b0;
            end
        end
    end

    assign phase_inc = r_phase_inc;
    assign inc_valid = w_inc_valid;
    assign period    = r_period;
    assign locked    = r_locked;
    assign noref     = r_noref;
    assign dbg_state = r_state;

endmodule
